// File: rtl/tdm_demux4.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux4
// Description : Four-channel TDM demultiplexer. Aligns to a frame marker,
//               collects the four time slots into shadow registers, and
//               publishes a complete frame on c0..c3 in a single edge.
//               Only whole frames reach the outputs.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               z, sync, en     - multiplexed data, slot-0 marker, sample strobe
//               c0..c3          - channel words from the last complete frame
//               s1, s0          - slot index of the next expected sample
//               frame_valid     - one-cycle pulse after c0..c3 update
//               sync_err        - one-cycle pulse per framing error
//               locked          - high while frame alignment is held
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux4 #(
    parameter int WIDTH  = 1,
    parameter bit STRICT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] z,
    input  logic             sync,
    input  logic             en,
    output logic [WIDTH-1:0] c0,
    output logic [WIDTH-1:0] c1,
    output logic [WIDTH-1:0] c2,
    output logic [WIDTH-1:0] c3,
    output logic             s1,
    output logic             s0,
    output logic             frame_valid,
    output logic             sync_err,
    output logic             locked
);

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_slot;
    logic [WIDTH-1:0] r_shadow0;
    logic [WIDTH-1:0] r_shadow1;
    logic [WIDTH-1:0] r_shadow2;
    logic [WIDTH-1:0] r_c0;
    logic [WIDTH-1:0] r_c1;
    logic [WIDTH-1:0] r_c2;
    logic [WIDTH-1:0] r_c3;
    logic             r_frame_valid;
    logic             r_sync_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= HUNT;
            r_slot        <= 2'd0;
            r_shadow0     <= '0;
            r_shadow1     <= '0;
            r_shadow2     <= '0;
            r_c0          <= '0;
            r_c1          <= '0;
            r_c2          <= '0;
            r_c3          <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            // Status flags are pulses: cleared unless re-asserted below.
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;

            if (en) begin
                case (r_state)
                    HUNT: begin
                        if (sync) begin
                            r_shadow0 <= z;
                            r_slot    <= 2'd1;
                            r_state   <= RUN;
                        end
                    end

                    RUN: begin
                        if (r_slot == 2'd0) begin
                            if (sync || !STRICT) begin
                                // Frame boundary: either marked, or free-running.
                                r_shadow0 <= z;
                                r_slot    <= 2'd1;
                            end else begin
                                // Marker missing where one was due: lose lock.
                                r_sync_err <= 1'b1;
                                r_slot     <= 2'd0;
                                r_state    <= HUNT;
                            end
                        end else if (sync) begin
                            // Early marker: abandon the partial frame and
                            // restart alignment on this sample.
                            r_sync_err <= 1'b1;
                            r_shadow0  <= z;
                            r_slot     <= 2'd1;
                        end else begin
                            case (r_slot)
                                2'd1: r_shadow1 <= z;
                                2'd2: r_shadow2 <= z;
                                2'd3: begin
                                    // Last slot goes straight to c3 so the
                                    // whole frame lands on one edge.
                                    r_c0          <= r_shadow0;
                                    r_c1          <= r_shadow1;
                                    r_c2          <= r_shadow2;
                                    r_c3          <= z;
                                    r_frame_valid <= 1'b1;
                                end
                                default: ;
                            endcase
                            r_slot <= r_slot + 2'd1;
                        end
                    end

                    default: begin
                        r_state <= HUNT;
                        r_slot  <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign c0          = r_c0;
    assign c1          = r_c1;
    assign c2          = r_c2;
    assign c3          = r_c3;
    assign s1          = r_slot[1];
    assign s0          = r_slot[0];
    assign frame_valid = r_frame_valid;
    assign sync_err    = r_sync_err;
    assign locked      = (r_state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux4.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_demux4
// Description : Testbench for tdm_demux4. Two instances (STRICT=1 and
//               STRICT=0) share one stimulus stream and are compared each
//               cycle against a sample-collecting reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic         sync = 1'b0;
    logic [W-1:0] z   = '0;

    always #5 clk = ~clk;

    logic [W-1:0] a_c0, a_c1, a_c2, a_c3;
    logic         a_s1, a_s0, a_fv, a_err, a_lk;
    logic [W-1:0] b_c0, b_c1, b_c2, b_c3;
    logic         b_s1, b_s0, b_fv, b_err, b_lk;

    tdm_demux4 #(.WIDTH(W), .STRICT(1'b1)) dut_strict (
        .clk(clk), .rst(rst), .z(z), .sync(sync), .en(en),
        .c0(a_c0), .c1(a_c1), .c2(a_c2), .c3(a_c3),
        .s1(a_s1), .s0(a_s0), .frame_valid(a_fv), .sync_err(a_err), .locked(a_lk)
    );

    tdm_demux4 #(.WIDTH(W), .STRICT(1'b0)) dut_free (
        .clk(clk), .rst(rst), .z(z), .sync(sync), .en(en),
        .c0(b_c0), .c1(b_c1), .c2(b_c2), .c3(b_c3),
        .s1(b_s1), .s0(b_s0), .frame_valid(b_fv), .sync_err(b_err), .locked(b_lk)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a count of samples collected in the current frame,
    // the samples themselves, and a lock flag. Index 0 = strict, 1 = free.
    bit           m_lock [2];
    int           m_cnt  [2];
    logic [W-1:0] m_buf  [2][4];
    logic [W-1:0] e_c    [2][4];
    bit           e_fv   [2];
    bit           e_err  [2];

    function automatic void model_update(int i, logic r, logic e, logic s, logic [W-1:0] zz);
        bit strict = (i == 0);
        if (r) begin
            m_lock[i] = 0;
            m_cnt[i]  = 0;
            e_fv[i]   = 0;
            e_err[i]  = 0;
            for (int k = 0; k < 4; k++) begin
                m_buf[i][k] = '0;
                e_c[i][k]   = '0;
            end
        end else begin
            e_fv[i]  = 0;
            e_err[i] = 0;
            if (e) begin
                if (s) begin
                    if (m_lock[i] && m_cnt[i] != 0) e_err[i] = 1;
                    m_buf[i][0] = zz;
                    m_cnt[i]    = 1;
                    m_lock[i]   = 1;
                end else if (m_lock[i]) begin
                    if (m_cnt[i] == 0) begin
                        if (strict) begin
                            e_err[i]  = 1;
                            m_lock[i] = 0;
                        end else begin
                            m_buf[i][0] = zz;
                            m_cnt[i]    = 1;
                        end
                    end else begin
                        m_buf[i][m_cnt[i]] = zz;
                        m_cnt[i] = m_cnt[i] + 1;
                        if (m_cnt[i] == 4) begin
                            for (int k = 0; k < 4; k++) e_c[i][k] = m_buf[i][k];
                            e_fv[i]  = 1;
                            m_cnt[i] = 0;
                        end
                    end
                end
            end
        end
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_inst(int i, logic [W-1:0] c0, logic [W-1:0] c1, logic [W-1:0] c2,
                            logic [W-1:0] c3, logic [1:0] sl, logic fv, logic er, logic lk);
        string p = (i == 0) ? "strict" : "free";
        chk({p, ".c0"},     32'(c0), 32'(e_c[i][0]));
        chk({p, ".c1"},     32'(c1), 32'(e_c[i][1]));
        chk({p, ".c2"},     32'(c2), 32'(e_c[i][2]));
        chk({p, ".c3"},     32'(c3), 32'(e_c[i][3]));
        chk({p, ".slot"},   32'(sl), 32'(m_cnt[i]));
        chk({p, ".fv"},     32'(fv), 32'(e_fv[i]));
        chk({p, ".err"},    32'(er), 32'(e_err[i]));
        chk({p, ".locked"}, 32'(lk), 32'(m_lock[i]));
    endtask

    task automatic step(logic r, logic e, logic s, logic [W-1:0] zz);
        rst = r; en = e; sync = s; z = zz;
        @(posedge clk);
        model_update(0, r, e, s, zz);
        model_update(1, r, e, s, zz);
        #1;
        chk_inst(0, a_c0, a_c1, a_c2, a_c3, {a_s1, a_s0}, a_fv, a_err, a_lk);
        chk_inst(1, b_c0, b_c1, b_c2, b_c3, {b_s1, b_s0}, b_fv, b_err, b_lk);
    endtask

    task automatic sample(logic s, logic [W-1:0] zz);
        step(1'b0, 1'b1, s, zz);
    endtask

    // en low: z and sync carry junk that must be ignored.
    task automatic idle();
        step(1'b0, 1'b0, 1'($urandom_range(0, 1)), W'($urandom));
    endtask

    int fv_cnt;
    int err_cnt;

    initial begin
        // Reset state, with en/sync active to show reset has priority.
        step(1'b1, 1'b1, 1'b1, 4'hF);
        chk("reset.outs", 32'({a_c0, a_c1, a_c2, a_c3, a_s1, a_s0, a_fv, a_err, a_lk}), 32'd0);

        // Nominal frame 1,0,1,1.
        sample(1'b1, 4'd1); sample(1'b0, 4'd0); sample(1'b0, 4'd1); sample(1'b0, 4'd1);
        chk("nominal.c", 32'({a_c0, a_c1, a_c2, a_c3}), 32'h1011);
        chk("nominal.fv", 32'(a_fv), 32'd1);
        chk("nominal.locked", 32'(a_lk), 32'd1);
        idle();
        chk("nominal.fv_drop", 32'(a_fv), 32'd0);

        // Gapped frame: 3 idle cycles between samples, new data values.
        sample(1'b1, 4'd6);
        repeat (3) idle();
        sample(1'b0, 4'd7);
        repeat (3) idle();
        sample(1'b0, 4'd8);
        repeat (3) idle();
        chk("gapped.c_held", 32'({a_c0, a_c1, a_c2, a_c3}), 32'h1011);
        sample(1'b0, 4'd9);
        chk("gapped.c", 32'({a_c0, a_c1, a_c2, a_c3}), 32'h6789);
        idle();

        // Early sync on the 3rd sample, then a full frame from that sync.
        sample(1'b1, 4'hA); sample(1'b0, 4'hB); sample(1'b1, 4'hC);
        chk("early.err", 32'(a_err), 32'd1);
        chk("early.c_held", 32'({a_c0, a_c1, a_c2, a_c3}), 32'h6789);
        sample(1'b0, 4'hD); sample(1'b0, 4'hE); sample(1'b0, 4'hF);
        chk("early.c", 32'({a_c0, a_c1, a_c2, a_c3}), 32'hCDEF);

        // Missing sync on the 5th sample: strict drops lock, free keeps going.
        sample(1'b0, 4'h3);
        chk("miss.strict_err", 32'(a_err), 32'd1);
        chk("miss.strict_locked", 32'(a_lk), 32'd0);
        chk("miss.strict_slot", 32'({a_s1, a_s0}), 32'd0);
        chk("miss.free_err", 32'(b_err), 32'd0);
        chk("miss.free_slot", 32'({b_s1, b_s0}), 32'd1);
        sample(1'b0, 4'h4);
        sample(1'b1, 4'h5);
        chk("miss.relock", 32'(a_lk), 32'd1);
        sample(1'b0, 4'h6); sample(1'b0, 4'h7); sample(1'b0, 4'h8);

        // Eight continuous samples with a single sync.
        step(1'b1, 1'b0, 1'b0, 4'h0);
        fv_cnt = 0; err_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            sample(k == 0, 4'(k + 1));
            fv_cnt  += int'(b_fv);
            err_cnt += int'(b_err);
        end
        chk("free8.fv_pulses", 32'(fv_cnt), 32'd2);
        chk("free8.err_pulses", 32'(err_cnt), 32'd0);
        chk("free8.c", 32'({b_c0, b_c1, b_c2, b_c3}), 32'h5678);

        // Reset mid-frame after 2 samples, then a fresh frame.
        sample(1'b1, 4'h2); sample(1'b0, 4'h3);
        step(1'b1, 1'b1, 1'b0, 4'hF);
        chk("midrst.outs", 32'({a_c0, a_c1, a_c2, a_c3, a_s1, a_s0, a_fv, a_err, a_lk}), 32'd0);
        sample(1'b0, 4'h9);
        chk("midrst.needs_sync", 32'(a_lk), 32'd0);
        sample(1'b1, 4'h4); sample(1'b0, 4'h3); sample(1'b0, 4'h2); sample(1'b0, 4'h1);
        chk("midrst.c", 32'({a_c0, a_c1, a_c2, a_c3}), 32'h4321);

        // Back-to-back frames: one pulse every 4 cycles.
        fv_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            sample((k % 4) == 0, W'($urandom));
            fv_cnt += int'(a_fv);
        end
        chk("b2b.fv_pulses", 32'(fv_cnt), 32'd4);

        // Random well-formed frames with gaps and occasional missing/early syncs.
        for (int f = 0; f < 30; f++) begin
            for (int k = 0; k < 4; k++) begin
                while ($urandom_range(0, 2) == 0) idle();
                if (k == 0)
                    sample($urandom_range(0, 7) != 0, W'($urandom));
                else
                    sample($urandom_range(0, 15) == 0, W'($urandom));
            end
        end

        // Fully random stream including occasional resets.
        for (int k = 0; k < 300; k++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) == 0, W'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
